// File: rtl/alu_pkg.sv
// Shared opcode/function encodings and the EX/MEM payload for the execute stage.
package alu_pkg;

    localparam int unsigned DATA_W = 32;
    localparam int unsigned REG_W  = 5;

    // Primary opcodes
    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_ADDIU = 6'b001001;
    localparam logic [5:0] OP_SLTI  = 6'b001010;
    localparam logic [5:0] OP_SLTIU = 6'b001011;
    localparam logic [5:0] OP_ANDI  = 6'b001100;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_XORI  = 6'b001110;
    localparam logic [5:0] OP_LUI   = 6'b001111;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;

    // R-type function codes
    localparam logic [5:0] FN_SLL  = 6'b000000;
    localparam logic [5:0] FN_SRL  = 6'b000010;
    localparam logic [5:0] FN_SRA  = 6'b000011;
    localparam logic [5:0] FN_SLLV = 6'b000100;
    localparam logic [5:0] FN_SRLV = 6'b000110;
    localparam logic [5:0] FN_SRAV = 6'b000111;
    localparam logic [5:0] FN_JR   = 6'b001000;
    localparam logic [5:0] FN_ADD  = 6'b100000;
    localparam logic [5:0] FN_ADDU = 6'b100001;
    localparam logic [5:0] FN_SUB  = 6'b100010;
    localparam logic [5:0] FN_SUBU = 6'b100011;
    localparam logic [5:0] FN_AND  = 6'b100100;
    localparam logic [5:0] FN_OR   = 6'b100101;
    localparam logic [5:0] FN_XOR  = 6'b100110;
    localparam logic [5:0] FN_NOR  = 6'b100111;
    localparam logic [5:0] FN_SLT  = 6'b101010;
    localparam logic [5:0] FN_SLTU = 6'b101011;

    // Everything latched into the EX/MEM boundary
    typedef struct packed {
        logic              rw_en;
        logic [REG_W-1:0]  rw;
        logic              mem_wea;
        logic              pcwr_en;
        logic [DATA_W-1:0] address;
        logic [DATA_W-1:0] f;
        logic              overflow;
        logic              zero;
        logic              carryout;
    } ex_mem_t;

endpackage

// File: rtl/alu_core.sv
// Combinational ALU: result, flags, branch/jump/memory address and control pass-through.
// Optional macro ALU_OVF_WB_SUPPRESS_EN: signed overflow on ADD/ADDI/SUB kills the writeback.
module alu_core
    import alu_pkg::*;
(
    input  logic [5:0]        i_op,
    input  logic [5:0]        i_func,
    input  logic [4:0]        i_shamt,
    input  logic [15:0]       i_imm,
    input  logic [DATA_W-1:0] i_s_imm,
    input  logic [DATA_W-1:0] i_u_imm,
    input  logic [DATA_W-1:0] i_addr,
    input  logic [DATA_W-1:0] i_a,
    input  logic [DATA_W-1:0] i_b,
    input  logic              i_rw_en,
    input  logic [REG_W-1:0]  i_rw,
    input  logic              i_mem_wea,
    input  logic              i_pcwr_en,
    output ex_mem_t           o_res_c
);

    logic              w_imm_op;
    logic [DATA_W-1:0] w_op2;
    logic [DATA_W:0]   w_sum;
    logic [DATA_W-1:0] w_diff;
    logic              w_borrow;
    logic              w_add_ovf;
    logic              w_sub_ovf;
    logic [DATA_W-1:0] w_f;
    logic [DATA_W-1:0] w_address;
    logic              w_ovf;
    logic              w_carry;
    logic              w_valid;
    logic              w_trap;
    logic              w_pc_en;
    logic              w_rw_en;

    // Second operand is the sign-extended immediate for immediate arithmetic and memory ops
    assign w_imm_op  = (i_op == OP_ADDI) || (i_op == OP_ADDIU) || (i_op == OP_LW) || (i_op == OP_SW);
    assign w_op2     = w_imm_op ? i_s_imm : i_b;
    assign w_sum     = {1'b0, i_a} + {1'b0, w_op2};
    assign w_diff    = i_a - w_op2;
    assign w_borrow  = (i_a < w_op2);
    assign w_add_ovf = (i_a[DATA_W-1] == w_op2[DATA_W-1]) && (w_sum[DATA_W-1] != i_a[DATA_W-1]);
    assign w_sub_ovf = (i_a[DATA_W-1] != w_op2[DATA_W-1]) && (w_diff[DATA_W-1] != i_a[DATA_W-1]);

    // Operation decode and result/flag selection
    always_comb begin
        w_f       = '0;
        w_address = '0;
        w_ovf     = 1'b0;
        w_carry   = 1'b0;
        w_valid   = 1'b1;
        w_trap    = 1'b0;
        w_pc_en   = i_pcwr_en;
        case (i_op)
            OP_RTYPE: begin
                case (i_func)
                    FN_ADD:  begin w_f = w_sum[DATA_W-1:0]; w_carry = w_sum[DATA_W];
                                   w_ovf = w_add_ovf; w_trap = w_add_ovf; end
                    FN_ADDU: begin w_f = w_sum[DATA_W-1:0]; w_carry = w_sum[DATA_W]; end
                    FN_SUB:  begin w_f = w_diff; w_carry = w_borrow;
                                   w_ovf = w_sub_ovf; w_trap = w_sub_ovf; end
                    FN_SUBU: begin w_f = w_diff; w_carry = w_borrow; end
                    FN_AND:  w_f = i_a & i_b;
                    FN_OR:   w_f = i_a | i_b;
                    FN_XOR:  w_f = i_a ^ i_b;
                    FN_NOR:  w_f = ~(i_a | i_b);
                    FN_SLT:  w_f = DATA_W'($signed(i_a) < $signed(i_b));
                    FN_SLTU: w_f = DATA_W'(i_a < i_b);
                    FN_SLL:  w_f = i_b << i_shamt;
                    FN_SRL:  w_f = i_b >> i_shamt;
                    FN_SRA:  w_f = DATA_W'($signed(i_b) >>> i_shamt);
                    FN_SLLV: w_f = i_b << i_a[4:0];
                    FN_SRLV: w_f = i_b >> i_a[4:0];
                    FN_SRAV: w_f = DATA_W'($signed(i_b) >>> i_a[4:0]);
                    FN_JR:   w_address = i_a;
                    default: w_valid = 1'b0;
                endcase
            end
            OP_J:     w_address = i_addr;
            OP_BEQ, OP_BNE: begin
                w_f       = w_diff;
                w_carry   = w_borrow;
                w_ovf     = w_sub_ovf;
                w_address = i_addr + (i_s_imm << 2);
                w_pc_en   = i_pcwr_en & ((i_op == OP_BEQ) ? (i_a == i_b) : (i_a != i_b));
            end
            OP_ADDI:  begin w_f = w_sum[DATA_W-1:0]; w_carry = w_sum[DATA_W];
                            w_ovf = w_add_ovf; w_trap = w_add_ovf; end
            OP_ADDIU: begin w_f = w_sum[DATA_W-1:0]; w_carry = w_sum[DATA_W]; end
            OP_SLTI:  w_f = DATA_W'($signed(i_a) < $signed(i_s_imm));
            OP_SLTIU: w_f = DATA_W'(i_a < i_s_imm);
            OP_ANDI:  w_f = i_a & i_u_imm;
            OP_ORI:   w_f = i_a | i_u_imm;
            OP_XORI:  w_f = i_a ^ i_u_imm;
            OP_LUI:   w_f = {i_imm, 16'h0000};
            OP_LW, OP_SW: begin
                w_f       = w_sum[DATA_W-1:0];
                w_address = w_sum[DATA_W-1:0];
            end
            default:  w_valid = 1'b0;
        endcase
    end

    // Writeback enable, optionally gated by a trapping overflow
    always_comb begin
        w_rw_en = i_rw_en;
`ifdef ALU_OVF_WB_SUPPRESS_EN
        if (w_trap) begin
            w_rw_en = 1'b0;
        end
`else
        if (w_trap) begin
            w_rw_en = i_rw_en;
        end
`endif
    end

    // Undefined encodings collapse to a NOP with all flags cleared
    always_comb begin
        o_res_c          = '0;
        o_res_c.rw       = i_rw;
        if (w_valid) begin
            o_res_c.rw_en    = w_rw_en;
            o_res_c.mem_wea  = i_mem_wea;
            o_res_c.pcwr_en  = w_pc_en;
            o_res_c.address  = w_address;
            o_res_c.f        = w_f;
            o_res_c.overflow = w_ovf;
            o_res_c.zero     = (w_f == '0);
            o_res_c.carryout = w_carry;
        end
    end

endmodule

// File: rtl/alu_ex_stage.sv
// MIPS execute stage: ALU core plus the EX/MEM register with stall/bubble control.
// Optional macro ALU_OVF_WB_SUPPRESS_EN (see alu_core) suppresses writeback on trapping overflow.
module alu_ex_stage
    import alu_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic [5:0]        stall_i,
    input  logic [DATA_W-1:0] addr_i,
    input  logic [5:0]        op_i,
    input  logic [4:0]        shamt_i,
    input  logic [5:0]        func_i,
    input  logic [15:0]       imm_i,
    input  logic [DATA_W-1:0] s_imm_i,
    input  logic [DATA_W-1:0] u_imm_i,
    input  logic              rw_en_i,
    input  logic [REG_W-1:0]  rw_i,
    input  logic              mem_wea_i,
    input  logic              pcwr_en_i,
    input  logic [DATA_W-1:0] A_i,
    input  logic [DATA_W-1:0] B_i,
    output logic              rw_en_o,
    output logic [REG_W-1:0]  rw_o,
    output logic              mem_wea_o,
    output logic              pcwr_en_o,
    output logic [DATA_W-1:0] address_o,
    output logic [DATA_W-1:0] F_o,
    output logic              overflow_o,
    output logic              zero_o,
    output logic              carryout_o
);

    ex_mem_t w_next;
    ex_mem_t r_ex_mem;
    logic    w_unused_stall;

    // Only the EX and MEM stall bits matter at this boundary
    assign w_unused_stall = ^{stall_i[5:4], stall_i[1:0]};

    alu_core u_core (
        .i_op      (op_i),
        .i_func    (func_i),
        .i_shamt   (shamt_i),
        .i_imm     (imm_i),
        .i_s_imm   (s_imm_i),
        .i_u_imm   (u_imm_i),
        .i_addr    (addr_i),
        .i_a       (A_i),
        .i_b       (B_i),
        .i_rw_en   (rw_en_i),
        .i_rw      (rw_i),
        .i_mem_wea (mem_wea_i),
        .i_pcwr_en (pcwr_en_i),
        .o_res_c   (w_next)
    );

    // EX/MEM register: load when EX runs, bubble when only EX stalls, hold when MEM stalls too
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ex_mem <= '0;
        end else if (!stall_i[2]) begin
            r_ex_mem <= w_next;
        end else if (!stall_i[3]) begin
            r_ex_mem <= '0;
        end
    end

    assign rw_en_o    = r_ex_mem.rw_en;
    assign rw_o       = r_ex_mem.rw;
    assign mem_wea_o  = r_ex_mem.mem_wea;
    assign pcwr_en_o  = r_ex_mem.pcwr_en;
    assign address_o  = r_ex_mem.address;
    assign F_o        = r_ex_mem.f;
    assign overflow_o = r_ex_mem.overflow;
    assign zero_o     = r_ex_mem.zero;
    assign carryout_o = r_ex_mem.carryout;

endmodule

// File: tb/tb_alu_ex_stage.sv
// Directed, table-driven bench for alu_ex_stage plus reset and stall sequences.
module tb_alu_ex_stage;

`ifdef ALU_OVF_WB_SUPPRESS_EN
    localparam bit SUPP = 1'b1;
`else
    localparam bit SUPP = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n;
    logic [5:0]  stall_i;
    logic [31:0] addr_i;
    logic [5:0]  op_i;
    logic [4:0]  shamt_i;
    logic [5:0]  func_i;
    logic [15:0] imm_i;
    logic [31:0] s_imm_i;
    logic [31:0] u_imm_i;
    logic        rw_en_i;
    logic [4:0]  rw_i;
    logic        mem_wea_i;
    logic        pcwr_en_i;
    logic [31:0] A_i;
    logic [31:0] B_i;
    logic        rw_en_o;
    logic [4:0]  rw_o;
    logic        mem_wea_o;
    logic        pcwr_en_o;
    logic [31:0] address_o;
    logic [31:0] F_o;
    logic        overflow_o;
    logic        zero_o;
    logic        carryout_o;

    int n_pass  = 0;
    int n_total = 0;

    always #5 clk = ~clk;

    alu_ex_stage dut (
        .clk(clk), .rst_n(rst_n), .stall_i(stall_i), .addr_i(addr_i), .op_i(op_i),
        .shamt_i(shamt_i), .func_i(func_i), .imm_i(imm_i), .s_imm_i(s_imm_i),
        .u_imm_i(u_imm_i), .rw_en_i(rw_en_i), .rw_i(rw_i), .mem_wea_i(mem_wea_i),
        .pcwr_en_i(pcwr_en_i), .A_i(A_i), .B_i(B_i), .rw_en_o(rw_en_o), .rw_o(rw_o),
        .mem_wea_o(mem_wea_o), .pcwr_en_o(pcwr_en_o), .address_o(address_o), .F_o(F_o),
        .overflow_o(overflow_o), .zero_o(zero_o), .carryout_o(carryout_o)
    );

    typedef struct {
        string       name;
        logic [5:0]  op;
        logic [5:0]  func;
        logic [4:0]  shamt;
        logic [15:0] imm;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] addr;
        logic        pc_in;
        logic        rw_in;
        logic        wea_in;
        logic [31:0] e_f;
        logic [31:0] e_addr;
        logic        e_ovf;
        logic        e_zero;
        logic        e_cy;
        logic        e_rw;
        logic        e_pc;
        logic        e_wea;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(input string n, input logic [5:0] op, input logic [5:0] fn,
                                input logic [4:0] sh, input logic [15:0] imm,
                                input logic [31:0] a, input logic [31:0] b, input logic [31:0] ad,
                                input logic pc, input logic rw, input logic wea,
                                input logic [31:0] ef, input logic [31:0] eaddr,
                                input logic eovf, input logic ez, input logic ecy,
                                input logic erw, input logic epc, input logic ewea);
        vec_t v;
        v.name = n; v.op = op; v.func = fn; v.shamt = sh; v.imm = imm;
        v.a = a; v.b = b; v.addr = ad; v.pc_in = pc; v.rw_in = rw; v.wea_in = wea;
        v.e_f = ef; v.e_addr = eaddr; v.e_ovf = eovf; v.e_zero = ez; v.e_cy = ecy;
        v.e_rw = erw; v.e_pc = epc; v.e_wea = ewea;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    endtask

    task automatic drive(input vec_t v, input logic [4:0] rw);
        op_i = v.op; func_i = v.func; shamt_i = v.shamt; imm_i = v.imm;
        s_imm_i = {{16{v.imm[15]}}, v.imm}; u_imm_i = {16'h0000, v.imm};
        A_i = v.a; B_i = v.b; addr_i = v.addr;
        pcwr_en_i = v.pc_in; rw_en_i = v.rw_in; mem_wea_i = v.wea_in; rw_i = rw;
    endtask

    task automatic check_vec(input vec_t v, input logic [4:0] rw);
        check({v.name, ".F"},        F_o,        v.e_f);
        check({v.name, ".address"},  address_o,  v.e_addr);
        check({v.name, ".overflow"}, 32'(overflow_o), 32'(v.e_ovf));
        check({v.name, ".zero"},     32'(zero_o),     32'(v.e_zero));
        check({v.name, ".carry"},    32'(carryout_o), 32'(v.e_cy));
        check({v.name, ".rw_en"},    32'(rw_en_o),    32'(v.e_rw));
        check({v.name, ".pcwr_en"},  32'(pcwr_en_o),  32'(v.e_pc));
        check({v.name, ".mem_wea"},  32'(mem_wea_o),  32'(v.e_wea));
        check({v.name, ".rw"},       32'(rw_o),       32'(rw));
    endtask

    task automatic check_zero(input string name);
        check({name, ".F"},       F_o, 32'h0);
        check({name, ".address"}, address_o, 32'h0);
        check({name, ".ctl"}, 32'({rw_en_o, rw_o, mem_wea_o, pcwr_en_o}), 32'h0);
        check({name, ".flags"}, 32'({overflow_o, zero_o, carryout_o}), 32'h0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t v;
        //                   name     op        func      sh     imm       A             B             addr          pc  rw  we   F             address       ov z  cy rw     pc we
        vecs.push_back(mk("add_ovf", 6'h00, 6'b100000, 5'd0, 16'h0000, 32'h7FFFFFFF, 32'h11111111, 32'h0,        0, 1, 0, 32'h91111110, 32'h0,        1, 0, 0, !SUPP, 0, 0));
        vecs.push_back(mk("and",     6'h00, 6'b100100, 5'd0, 16'h0000, 32'd15,       32'd61,       32'h0,        0, 1, 0, 32'd13,       32'h0,        0, 0, 0, 1,     0, 0));
        vecs.push_back(mk("sub_eq",  6'h00, 6'b100010, 5'd0, 16'h0000, 32'd5,        32'd5,        32'h0,        0, 1, 0, 32'h0,        32'h0,        0, 1, 0, 1,     0, 0));
        vecs.push_back(mk("j",       6'h02, 6'b000000, 5'd0, 16'h0000, 32'h0,        32'h0,        32'h00CAB020, 1, 0, 0, 32'h0,        32'h00CAB020, 0, 1, 0, 0,     1, 0));
        vecs.push_back(mk("beq_nt",  6'h04, 6'b000000, 5'd0, 16'h3434, 32'd15,       32'd61,       32'h0,        1, 0, 0, 32'hFFFFFFD2, 32'h0000D0D0, 0, 0, 1, 0,     0, 0));
        vecs.push_back(mk("beq_t",   6'h04, 6'b000000, 5'd0, 16'h3434, 32'd15,       32'd15,       32'h0,        1, 0, 0, 32'h0,        32'h0000D0D0, 0, 1, 0, 0,     1, 0));
        vecs.push_back(mk("bne_t",   6'h05, 6'b000000, 5'd0, 16'hFFFF, 32'd15,       32'd61,       32'h100,      1, 0, 0, 32'hFFFFFFD2, 32'h000000FC, 0, 0, 1, 0,     1, 0));
        vecs.push_back(mk("addi",    6'h08, 6'b000000, 5'd0, 16'h3434, 32'd15,       32'h0,        32'h0,        0, 1, 0, 32'h00003443, 32'h0,        0, 0, 0, 1,     0, 0));
        vecs.push_back(mk("slti",    6'h0A, 6'b000000, 5'd0, 16'hFFFF, 32'd1,        32'h0,        32'h0,        0, 1, 0, 32'h0,        32'h0,        0, 1, 0, 1,     0, 0));
        vecs.push_back(mk("sltiu",   6'h0B, 6'b000000, 5'd0, 16'hFFFF, 32'd1,        32'h0,        32'h0,        0, 1, 0, 32'h1,        32'h0,        0, 0, 0, 1,     0, 0));
        vecs.push_back(mk("lui",     6'h0F, 6'b000000, 5'd0, 16'h1234, 32'hDEADBEEF, 32'h0,        32'h0,        0, 1, 0, 32'h12340000, 32'h0,        0, 0, 0, 1,     0, 0));
        vecs.push_back(mk("sra",     6'h00, 6'b000011, 5'd4, 16'h0000, 32'h0,        32'h80000000, 32'h0,        0, 1, 0, 32'hF8000000, 32'h0,        0, 0, 0, 1,     0, 0));
        vecs.push_back(mk("slt",     6'h00, 6'b101010, 5'd0, 16'h0000, 32'hFFFFFFFF, 32'd1,        32'h0,        0, 1, 0, 32'h1,        32'h0,        0, 0, 0, 1,     0, 0));
        vecs.push_back(mk("sltu",    6'h00, 6'b101011, 5'd0, 16'h0000, 32'hFFFFFFFF, 32'd1,        32'h0,        0, 1, 0, 32'h0,        32'h0,        0, 1, 0, 1,     0, 0));
        vecs.push_back(mk("sub_ovf", 6'h00, 6'b100010, 5'd0, 16'h0000, 32'h80000000, 32'd1,        32'h0,        0, 1, 0, 32'h7FFFFFFF, 32'h0,        1, 0, 0, !SUPP, 0, 0));
        vecs.push_back(mk("addu_cy", 6'h00, 6'b100001, 5'd0, 16'h0000, 32'hFFFFFFFF, 32'd1,        32'h0,        0, 1, 0, 32'h0,        32'h0,        0, 1, 1, 1,     0, 0));
        vecs.push_back(mk("subu_bw", 6'h00, 6'b100011, 5'd0, 16'h0000, 32'd3,        32'd5,        32'h0,        0, 1, 0, 32'hFFFFFFFE, 32'h0,        0, 0, 1, 1,     0, 0));
        vecs.push_back(mk("jr",      6'h00, 6'b001000, 5'd0, 16'h0000, 32'h00400010, 32'h0,        32'h0,        1, 0, 0, 32'h0,        32'h00400010, 0, 1, 0, 0,     1, 0));
        vecs.push_back(mk("lw",      6'h23, 6'b000000, 5'd0, 16'h0010, 32'h00001000, 32'h0,        32'h0,        0, 1, 0, 32'h00001010, 32'h00001010, 0, 0, 0, 1,     0, 0));
        vecs.push_back(mk("sw",      6'h2B, 6'b000000, 5'd0, 16'hFFF8, 32'h00002000, 32'h5,        32'h0,        0, 0, 1, 32'h00001FF8, 32'h00001FF8, 0, 0, 0, 0,     0, 1));
        vecs.push_back(mk("srlv",    6'h00, 6'b000110, 5'd0, 16'h0000, 32'd4,        32'h80000000, 32'h0,        0, 1, 0, 32'h08000000, 32'h0,        0, 0, 0, 1,     0, 0));
        vecs.push_back(mk("nor",     6'h00, 6'b100111, 5'd0, 16'h0000, 32'h0,        32'h0,        32'h0,        0, 1, 0, 32'hFFFFFFFF, 32'h0,        0, 0, 0, 1,     0, 0));
        vecs.push_back(mk("xori",    6'h0E, 6'b000000, 5'd0, 16'h0FF0, 32'hFF00FF00, 32'h0,        32'h0,        0, 1, 0, 32'hFF00F0F0, 32'h0,        0, 0, 0, 1,     0, 0));
        vecs.push_back(mk("ori_u",   6'h0D, 6'b000000, 5'd0, 16'h8000, 32'h0,        32'h0,        32'h0,        0, 1, 0, 32'h00008000, 32'h0,        0, 0, 0, 1,     0, 0));
        vecs.push_back(mk("bad_op",  6'h3F, 6'b000000, 5'd0, 16'h1234, 32'd7,        32'd9,        32'h40,       1, 1, 1, 32'h0,        32'h0,        0, 0, 0, 0,     0, 0));
        vecs.push_back(mk("bad_fn",  6'h00, 6'b111111, 5'd0, 16'h0000, 32'd7,        32'd9,        32'h0,        1, 1, 1, 32'h0,        32'h0,        0, 0, 0, 0,     0, 0));

        // Reset state
        rst_n = 1'b0; stall_i = 6'b0;
        drive(vecs[0], 5'd3);
        repeat (2) @(posedge clk);
        #1;
        check_zero("reset");

        @(negedge clk);
        rst_n = 1'b1;

        // Table vectors, one per clock
        for (int i = 0; i < vecs.size(); i++) begin
            @(negedge clk);
            drive(vecs[i], 5'(i + 1));
            @(posedge clk);
            #1;
            check_vec(vecs[i], 5'(i + 1));
        end

        // Bubble: EX stalled, MEM running
        @(negedge clk);
        drive(vecs[7], 5'd10);
        stall_i = 6'b000000;
        @(posedge clk); #1;
        check("pre_bubble.F", F_o, 32'h00003443);
        @(negedge clk);
        drive(vecs[1], 5'd11);
        stall_i = 6'b000100;
        @(posedge clk); #1;
        check_zero("bubble");

        // Hold: EX and MEM both stalled
        @(negedge clk);
        drive(vecs[11], 5'd12);
        stall_i = 6'b000000;
        @(posedge clk); #1;
        check_vec(vecs[11], 5'd12);
        @(negedge clk);
        drive(vecs[1], 5'd13);
        stall_i = 6'b001100;
        @(posedge clk); #1;
        check_vec(vecs[11], 5'd12);
        @(posedge clk); #1;
        check("hold2.F", F_o, 32'hF8000000);

        // MEM stalled alone does not stop EX
        @(negedge clk);
        stall_i = 6'b001000;
        @(posedge clk); #1;
        check_vec(vecs[1], 5'd13);

        // Unrelated stall bits are ignored
        @(negedge clk);
        drive(vecs[7], 5'd14);
        stall_i = 6'b110011;
        @(posedge clk); #1;
        check_vec(vecs[7], 5'd14);

        // Asynchronous reset clears without a clock edge
        @(negedge clk);
        stall_i = 6'b000000;
        #2;
        rst_n = 1'b0;
        #1;
        check_zero("async_reset");
        @(negedge clk);
        rst_n = 1'b1;

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
